me_full_search: RTL and testbench

//   Parametrised full-search integer motion estimator for the inter-prediction path.

---
 rtl/me_full_search.sv | 252 +++++++++++++++++++++++++
 tb/tb_me_full_search.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/me_full_search.sv
// rtl/me_full_search.sv - full-search integer motion estimator (minimum-SAD block match)
// Optional early termination of hopeless candidates: define ME_EARLY_TERM_EN.
module me_full_search #(
  parameter int MACRO_DIM  = 16,
  parameter int SEARCH_DIM = 48,
  parameter int PIXEL_W    = 8,
  localparam int N_POS = SEARCH_DIM - MACRO_DIM + 1,
  localparam int MVW   = $clog2(N_POS),
  localparam int SADW  = PIXEL_W + 2 * $clog2(MACRO_DIM),
  localparam int CRW   = $clog2(MACRO_DIM),
  localparam int SAW   = $clog2(SEARCH_DIM)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  output logic                         ready,
  output logic                         valid,
  output logic                         rd_en,
  output logic [CRW-1:0]               cur_row,
  output logic [SAW-1:0]               srch_row,
  output logic [SAW-1:0]               srch_col,
  input  logic [MACRO_DIM*PIXEL_W-1:0] cur_pixels,
  input  logic [MACRO_DIM*PIXEL_W-1:0] srch_pixels,
  output logic [MVW-1:0]               mv_x,
  output logic [MVW-1:0]               mv_y,
  output logic [SADW-1:0]              min_sad
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [CRW-1:0] R_LAST = CRW'(MACRO_DIM - 1);
  localparam logic [MVW-1:0] P_LAST = MVW'(N_POS - 1);

  state_t          state_q, state_d;
  logic            ready_q, ready_d, valid_q, valid_d, rd_en_q, rd_en_d;
  logic [CRW-1:0]  r_q, r_d;
  logic [MVW-1:0]  x_q, x_d, y_q, y_d;
  logic [SAW-1:0]  srow_q, srow_d;
  logic [1:0]      drain_q, drain_d;

  logic            p1_vld_q, p1_vld_d, p1_first_q, p1_first_d, p1_last_q, p1_last_d;
  logic [MVW-1:0]  p1_x_q, p1_x_d, p1_y_q, p1_y_d;
  logic            p2_vld_q, p2_vld_d, p2_first_q, p2_first_d, p2_last_q, p2_last_d;
  logic [MVW-1:0]  p2_x_q, p2_x_d, p2_y_q, p2_y_d;
  logic [SADW-1:0] row_sad_q, row_sad_d;
  logic            acc_vld_q, acc_vld_d, acc_last_q, acc_last_d;
  logic [MVW-1:0]  acc_x_q, acc_x_d, acc_y_q, acc_y_d;
  logic [SADW-1:0] acc_q, acc_d;

  logic [SADW-1:0] best_sad_q, best_sad_d;
  logic [MVW-1:0]  best_x_q, best_x_d, best_y_q, best_y_d;
  logic [MVW-1:0]  mv_x_q, mv_x_d, mv_y_q, mv_y_d;
  logic [SADW-1:0] min_sad_q, min_sad_d;

  logic            kill;
  logic [SADW-1:0] row_sum;

  function automatic logic [PIXEL_W-1:0] abs_diff(input logic [PIXEL_W-1:0] a,
                                                  input logic [PIXEL_W-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  always_comb begin
    row_sum = '0;
    for (int i = 0; i < MACRO_DIM; i++) begin
      row_sum = row_sum + SADW'(abs_diff(cur_pixels[i*PIXEL_W +: PIXEL_W],
                                         srch_pixels[i*PIXEL_W +: PIXEL_W]));
    end
  end

  // A partial sum already at or above the best can never win the strict compare.
`ifdef ME_EARLY_TERM_EN
  assign kill = acc_vld_q && !acc_last_q && (acc_x_q != '0 || acc_y_q != '0) &&
                (acc_q >= best_sad_q);
`else
  assign kill = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    ready_d   = ready_q;
    valid_d   = 1'b0;
    rd_en_d   = rd_en_q;
    r_d       = r_q;
    x_d       = x_q;
    y_d       = y_q;
    drain_d   = drain_q;
    mv_x_d    = mv_x_q;
    mv_y_d    = mv_y_q;
    min_sad_d = min_sad_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          ready_d = 1'b0;
          rd_en_d = 1'b1;
          r_d     = '0;
          x_d     = '0;
          y_d     = '0;
        end
      end
      S_RUN: begin
        if (r_q == R_LAST || (kill && x_q == acc_x_q && y_q == acc_y_q)) begin
          if (x_q == P_LAST && y_q == P_LAST) begin
            state_d = S_DRAIN;
            rd_en_d = 1'b0;
            drain_d = '0;
          end else begin
            r_d = '0;
            if (x_q == P_LAST) begin
              x_d = '0;
              y_d = y_q + 1'b1;
            end else begin
              x_d = x_q + 1'b1;
            end
          end
        end else begin
          r_d = r_q + 1'b1;
        end
      end
      S_DRAIN: begin
        drain_d = drain_q + 2'd1;
        if (drain_q == 2'd3) begin
          state_d   = S_DONE;
          valid_d   = 1'b1;
          mv_x_d    = best_x_q;
          mv_y_d    = best_y_q;
          min_sad_d = best_sad_q;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    srow_d = SAW'(y_d) + SAW'(r_d);

    // Each stage carries its candidate tag so a kill can drop only that candidate's rows.
    p1_vld_d   = rd_en_q && !(kill && x_q == acc_x_q && y_q == acc_y_q);
    p1_first_d = (r_q == '0);
    p1_last_d  = (r_q == R_LAST);
    p1_x_d     = x_q;
    p1_y_d     = y_q;

    p2_vld_d   = p1_vld_q && !(kill && p1_x_q == acc_x_q && p1_y_q == acc_y_q);
    p2_first_d = p1_first_q;
    p2_last_d  = p1_last_q;
    p2_x_d     = p1_x_q;
    p2_y_d     = p1_y_q;
    row_sad_d  = row_sum;

    acc_vld_d  = p2_vld_q && !(kill && p2_x_q == acc_x_q && p2_y_q == acc_y_q);
    acc_last_d = p2_last_q;
    acc_x_d    = p2_x_q;
    acc_y_d    = p2_y_q;
    acc_d      = acc_q;
    if (acc_vld_d) begin
      acc_d = p2_first_q ? row_sad_q : (acc_q + row_sad_q);
    end

    best_sad_d = best_sad_q;
    best_x_d   = best_x_q;
    best_y_d   = best_y_q;
    if (acc_vld_q && acc_last_q &&
        ((acc_x_q == '0 && acc_y_q == '0) || acc_q < best_sad_q)) begin
      best_sad_d = acc_q;
      best_x_d   = acc_x_q;
      best_y_d   = acc_y_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ready_q    <= 1'b1;
      valid_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      r_q        <= '0;
      x_q        <= '0;
      y_q        <= '0;
      srow_q     <= '0;
      drain_q    <= '0;
      p1_vld_q   <= 1'b0;
      p1_first_q <= 1'b0;
      p1_last_q  <= 1'b0;
      p1_x_q     <= '0;
      p1_y_q     <= '0;
      p2_vld_q   <= 1'b0;
      p2_first_q <= 1'b0;
      p2_last_q  <= 1'b0;
      p2_x_q     <= '0;
      p2_y_q     <= '0;
      row_sad_q  <= '0;
      acc_vld_q  <= 1'b0;
      acc_last_q <= 1'b0;
      acc_x_q    <= '0;
      acc_y_q    <= '0;
      acc_q      <= '0;
      best_sad_q <= '0;
      best_x_q   <= '0;
      best_y_q   <= '0;
      mv_x_q     <= '0;
      mv_y_q     <= '0;
      min_sad_q  <= '0;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      valid_q    <= valid_d;
      rd_en_q    <= rd_en_d;
      r_q        <= r_d;
      x_q        <= x_d;
      y_q        <= y_d;
      srow_q     <= srow_d;
      drain_q    <= drain_d;
      p1_vld_q   <= p1_vld_d;
      p1_first_q <= p1_first_d;
      p1_last_q  <= p1_last_d;
      p1_x_q     <= p1_x_d;
      p1_y_q     <= p1_y_d;
      p2_vld_q   <= p2_vld_d;
      p2_first_q <= p2_first_d;
      p2_last_q  <= p2_last_d;
      p2_x_q     <= p2_x_d;
      p2_y_q     <= p2_y_d;
      row_sad_q  <= row_sad_d;
      acc_vld_q  <= acc_vld_d;
      acc_last_q <= acc_last_d;
      acc_x_q    <= acc_x_d;
      acc_y_q    <= acc_y_d;
      acc_q      <= acc_d;
      best_sad_q <= best_sad_d;
      best_x_q   <= best_x_d;
      best_y_q   <= best_y_d;
      mv_x_q     <= mv_x_d;
      mv_y_q     <= mv_y_d;
      min_sad_q  <= min_sad_d;
    end
  end

  assign ready    = ready_q;
  assign valid    = valid_q;
  assign rd_en    = rd_en_q;
  assign cur_row  = r_q;
  assign srch_row = srow_q;
  assign srch_col = SAW'(x_q);
  assign mv_x     = mv_x_q;
  assign mv_y     = mv_y_q;
  assign min_sad  = min_sad_q;

endmodule

// File: tb/tb_me_full_search.sv
// tb/tb_me_full_search.sv - directed self-checking bench for me_full_search
// Row-read memory model answers rd_en one cycle later; expected values are hand-derived.
module tb_me_full_search;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         ready, valid, rd_en;
  logic [3:0]   cur_row;
  logic [5:0]   srch_row, srch_col;
  logic [127:0] cur_pixels, srch_pixels;
  logic [5:0]   mv_x, mv_y;
  logic [15:0]  min_sad;

  logic [7:0] cur_m [16][16];
  logic [7:0] win_m [48][48];

  int checks   = 0;
  int failures = 0;

  me_full_search dut (
    .clk(clk), .rst(rst), .start(start), .ready(ready), .valid(valid), .rd_en(rd_en),
    .cur_row(cur_row), .srch_row(srch_row), .srch_col(srch_col),
    .cur_pixels(cur_pixels), .srch_pixels(srch_pixels),
    .mv_x(mv_x), .mv_y(mv_y), .min_sad(min_sad)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd_en) begin
      for (int i = 0; i < 16; i++) begin
        cur_pixels[i*8 +: 8]  <= cur_m[cur_row][i];
        srch_pixels[i*8 +: 8] <= win_m[srch_row][int'(srch_col) + i];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic fill_const(input logic [7:0] cv, input logic [7:0] wv);
    for (int r = 0; r < 16; r++) for (int c = 0; c < 16; c++) cur_m[r][c] = cv;
    for (int r = 0; r < 48; r++) for (int c = 0; c < 48; c++) win_m[r][c] = wv;
  endtask

  task automatic fill_copy(input int oy, input int ox);
    for (int r = 0; r < 48; r++) for (int c = 0; c < 48; c++) win_m[r][c] = 8'($urandom);
    for (int r = 0; r < 16; r++) for (int c = 0; c < 16; c++) cur_m[r][c] = win_m[oy+r][ox+c];
  endtask

  // Called at #1 after an edge; the following edge is edge 0 of the search.
  task automatic run_search(input int hold, input bit pulses, input bit addr_chk,
                            output int vcyc, output bit rdy_bad);
    vcyc    = -1;
    rdy_bad = 1'b0;
    start   = 1'b1;
    @(posedge clk); #1;
    for (int cyc = 1; cyc <= 20000; cyc++) begin
      start = (cyc < hold) || (pulses && (cyc == 300 || cyc == 9000));
      @(posedge clk); #1;
      if (ready) rdy_bad = 1'b1;
      if (addr_chk && cyc == 2787) begin
        chk("rd_mid_en", rd_en, 1);
        chk("rd_mid_cur_row", cur_row, 3);
        chk("rd_mid_srch_row", srch_row, 8);
        chk("rd_mid_srch_col", srch_col, 9);
      end
      if (addr_chk && cyc == 17423) begin
        chk("rd_last_cur_row", cur_row, 15);
        chk("rd_last_srch_row", srch_row, 47);
        chk("rd_last_srch_col", srch_col, 32);
      end
      if (addr_chk && cyc == 17424) chk("rd_off_after_last", rd_en, 0);
      if (valid) begin
        vcyc = cyc;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic ref_model(output int bx, output int by, output int bs);
    bs = -1; bx = 0; by = 0;
    for (int y = 0; y < 33; y++) begin
      for (int x = 0; x < 33; x++) begin
        int s;
        s = 0;
        for (int r = 0; r < 16; r++) for (int c = 0; c < 16; c++) begin
          int d;
          d = int'(cur_m[r][c]) - int'(win_m[y+r][x+c]);
          s += (d < 0) ? -d : d;
        end
        if (bs < 0 || s < bs) begin bs = s; bx = x; by = y; end
      end
    end
  endtask

  initial begin
    int vcyc;
    bit rdy_bad;
    rst   = 1'b1;
    start = 1'b0;
    fill_const(8'h00, 8'h00);
    @(posedge clk); #1;
    chk("rst_ready", ready, 1);
    chk("rst_valid", valid, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_cur_row", cur_row, 0);
    chk("rst_srch_row", srch_row, 0);
    chk("rst_srch_col", srch_col, 0);
    chk("rst_mv_x", mv_x, 0);
    chk("rst_mv_y", mv_y, 0);
    chk("rst_min_sad", min_sad, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Flat picture: every SAD ties at zero, first position must win.
    fill_const(8'h10, 8'h10);
    run_search(1, 1'b0, 1'b0, vcyc, rdy_bad);
`ifdef ME_EARLY_TERM_EN
    chk("flat_latency_bound", (vcyc > 0 && vcyc <= 17428), 1);
`else
    chk("flat_latency", vcyc, 17428);
`endif
    chk("flat_mv_x", mv_x, 0);
    chk("flat_mv_y", mv_y, 0);
    chk("flat_min_sad", min_sad, 0);
    @(posedge clk); #1;
    chk("flat_valid_one_cycle", valid, 0);
    chk("flat_ready_back", ready, 1);

    // Back-to-back start; max SAD everywhere, start held and re-pulsed mid-search.
    fill_const(8'hFF, 8'h00);
    run_search(100, 1'b1, 1'b1, vcyc, rdy_bad);
    chk("max_latency", vcyc, 17428);
    chk("max_ready_low", rdy_bad, 0);
    chk("max_mv_x", mv_x, 0);
    chk("max_mv_y", mv_y, 0);
    chk("max_min_sad", min_sad, 16'hFF00);
    @(posedge clk); #1;
    chk("max_valid_one_cycle", valid, 0);

    // Abort a search with reset part way through.
    fill_copy(5, 9);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c < 5000; c++) begin
      @(posedge clk); #1;
    end
    chk("abort_busy_before", rd_en, 1);
    rst = 1'b1;
    #1;
    chk("abort_ready", ready, 1);
    chk("abort_valid", valid, 0);
    chk("abort_rd_en", rd_en, 0);
    chk("abort_srch_row", srch_row, 0);
    chk("abort_srch_col", srch_col, 0);
    chk("abort_min_sad", min_sad, 0);
    chk("abort_mv_x", mv_x, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Current block copied from window row 5, column 9.
    run_search(1, 1'b0, 1'b0, vcyc, rdy_bad);
`ifdef ME_EARLY_TERM_EN
    chk("copy_latency_early", (vcyc > 0 && vcyc < 17428), 1);
`else
    chk("copy_latency", vcyc, 17428);
`endif
    chk("copy_mv_x", mv_x, 9);
    chk("copy_mv_y", mv_y, 5);
    chk("copy_min_sad", min_sad, 0);

`ifdef ME_EARLY_TERM_EN
    begin
      int bx, by, bs;
      for (int r = 0; r < 48; r++) for (int c = 0; c < 48; c++) win_m[r][c] = 8'($urandom);
      for (int r = 0; r < 16; r++) for (int c = 0; c < 16; c++) cur_m[r][c] = 8'($urandom);
      ref_model(bx, by, bs);
      @(posedge clk); #1;
      run_search(1, 1'b0, 1'b0, vcyc, rdy_bad);
      chk("rand_latency_bound", (vcyc > 0 && vcyc <= 17428), 1);
      chk("rand_mv_x", mv_x, bx);
      chk("rand_mv_y", mv_y, by);
      chk("rand_min_sad", min_sad, bs);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
